// File: rtl/result_display_if.sv
// Result/strobe handshake from the arithmetic unit and the 7-segment drive
// lines of the result_display block.
//   result        8-bit unsigned result word
//   error         overflow/error flag, qualified by result_valid
//   result_valid  one-cycle strobe
//   busy          conversion in progress (strobes ignored)
//   done          one-cycle pulse when new digits are committed
//   seg           {g,f,e,d,c,b,a}, active-low
//   an            digit enables, active-low (0=units, 1=tens, 2=hundreds)
interface result_display_if;
  logic [7:0] result;
  logic       error;
  logic       result_valid;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [2:0] an;

  modport master (
    output result, error, result_valid,
    input  busy, done, seg, an
  );

  modport slave (
    input  result, error, result_valid,
    output busy, done, seg, an
  );
endinterface

// File: rtl/result_display.sv
// Display stage for the 8-bit arithmetic result: sequential double-dabble
// binary-to-BCD conversion, three-digit multiplexed active-low 7-segment
// scan with leading-zero blanking, and blinking while the error flag is set.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  result/strobe inputs and busy/done/seg/an outputs (slave side)
module result_display #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input logic             clk,
  input logic             rst,
  result_display_if.slave bus
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned ITER_W  = 3;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned BIN_W   = 8;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
  typedef enum logic [1:0] {DIG_UNITS, DIG_TENS, DIG_HUNDS} digit_t;

  state_t             state, state_nx;
  logic [BIN_W-1:0]   bin;
  logic [BCD_W-1:0]   bcd, bcd_adj;
  logic [ITER_W-1:0]  iter;
  logic               err_lat;

  logic [3:0]         disp_u, disp_t, disp_h;
  logic               disp_err;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  logic [SCAN_W-1:0]  scan_cnt;
  digit_t             scan_idx, scan_idx_nx;
  logic [3:0]         cur_digit;
  logic               cur_blank;
  logic [2:0]         an_nx;
  logic [6:0]         seg_nx;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.result_valid) state_nx = CONVERT;
      CONVERT: if (iter == ITER_W'(7)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Double-dabble correction: nibbles >= 5 get +3 before the shift
  always_comb begin
    bcd_adj        = bcd;
    bcd_adj[3:0]   = (bcd[3:0]   >= 4'd5) ? bcd[3:0]   + 4'd3 : bcd[3:0];
    bcd_adj[7:4]   = (bcd[7:4]   >= 4'd5) ? bcd[7:4]   + 4'd3 : bcd[7:4];
    bcd_adj[11:8]  = (bcd[11:8]  >= 4'd5) ? bcd[11:8]  + 4'd3 : bcd[11:8];
  end

  // Conversion datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin     <= '0;
      bcd     <= '0;
      iter    <= '0;
      err_lat <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.result_valid) begin
            bin     <= bus.result;
            err_lat <= bus.error;
            bcd     <= '0;
            iter    <= '0;
          end
        end
        CONVERT: begin
          {bcd, bin} <= (BCD_W+BIN_W)'({bcd_adj, bin} << 1);
          iter       <= iter + ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs, registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_nx != IDLE);
      bus.done <= (state_nx == COMMIT);
    end
  end

  // Display registers: only written when a conversion commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_u   <= '0;
      disp_t   <= '0;
      disp_h   <= '0;
      disp_err <= 1'b0;
    end else if (state == COMMIT) begin
      disp_u   <= bcd[3:0];
      disp_t   <= bcd[7:4];
      disp_h   <= bcd[11:8];
      disp_err <= err_lat;
    end
  end

  // Blink timer: runs only while the displayed error flag is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (state == COMMIT || !disp_err) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // scan_idx names the digit shown at the next scan step, so the first
  // step after reset shows units.
  always_comb begin
    cur_digit   = disp_u;
    cur_blank   = 1'b0;
    an_nx       = 3'b110;
    scan_idx_nx = DIG_TENS;
    unique case (scan_idx)
      DIG_TENS: begin
        cur_digit   = disp_t;
        cur_blank   = (disp_h == 4'd0) && (disp_t == 4'd0);
        an_nx       = 3'b101;
        scan_idx_nx = DIG_HUNDS;
      end
      DIG_HUNDS: begin
        cur_digit   = disp_h;
        cur_blank   = (disp_h == 4'd0);
        an_nx       = 3'b011;
        scan_idx_nx = DIG_UNITS;
      end
      default: ;
    endcase
    if (disp_err && !blink_on) cur_blank = 1'b1;
    seg_nx = cur_blank ? 7'b1111111 : seg_decode(cur_digit);
  end

  // Scan counter and registered digit drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= DIG_UNITS;
      bus.an   <= 3'b111;
      bus.seg  <= 7'b1111111;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx_nx;
      bus.an   <= an_nx;
      bus.seg  <= seg_nx;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;
  localparam int SD = 4;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_display_if bus ();

  result_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  logic [6:0] dec_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Behavioural model state
  int         m_cnt;   // cycles of busy remaining; 1 = commit cycle
  int         m_val;
  bit         m_err;
  int         d_val;
  bit         d_err;
  int         b_cnt;
  bit         b_on;
  int         s_cnt;
  int         s_idx;
  logic [6:0] m_seg;
  logic [2:0] m_an;

  function automatic logic [6:0] exp_seg(input int idx);
    int h, t, u, d;
    bit blank;
    h = d_val / 100;
    t = (d_val / 10) % 10;
    u = d_val % 10;
    d = u;
    blank = 1'b0;
    if (idx == 1) begin d = t; blank = (h == 0) && (t == 0); end
    if (idx == 2) begin d = h; blank = (h == 0); end
    if (d_err && !b_on) blank = 1'b1;
    return blank ? 7'b1111111 : dec_tab[d];
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Model: one update per clock, all decisions from pre-edge values
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_val = 0; m_err = 0; d_val = 0; d_err = 0;
      b_cnt = 0; b_on = 1; s_cnt = 0; s_idx = 0;
      m_seg = 7'b1111111; m_an = 3'b111;
    end else begin
      if (s_cnt == SD - 1) begin
        s_cnt = 0;
        m_an = 3'b111;
        m_an[s_idx] = 1'b0;
        m_seg = exp_seg(s_idx);
        s_idx = (s_idx + 1) % 3;
      end else begin
        s_cnt++;
      end
      if (m_cnt == 1 || !d_err) begin
        b_cnt = 0; b_on = 1;
      end else if (b_cnt == BD - 1) begin
        b_cnt = 0; b_on = !b_on;
      end else begin
        b_cnt++;
      end
      if (m_cnt == 0) begin
        if (bus.result_valid) begin
          m_val = bus.result; m_err = bus.error; m_cnt = 9;
        end
      end else begin
        if (m_cnt == 1) begin d_val = m_val; d_err = m_err; end
        m_cnt--;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    checks++;
    if (bus.busy !== (m_cnt > 0) || bus.done !== (m_cnt == 1) ||
        bus.seg !== m_seg || bus.an !== m_an) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t busy=%b/%b done=%b/%b seg=%b/%b an=%b/%b",
               $time, bus.busy, (m_cnt > 0), bus.done, (m_cnt == 1),
               bus.seg, m_seg, bus.an, m_an);
    end
  end

  always @(negedge clk) if (bus.done === 1'b1) done_count++;

  // Called at a negedge; value sampled at the next posedge
  task automatic strobe(input int v, input bit e);
    bus.result = 8'(v);
    bus.error = e;
    bus.result_valid = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    bus.error = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic capture(output logic [6:0] cu, output logic [6:0] ct,
                         output logic [6:0] ch, output int seen);
    cu = 'x; ct = 'x; ch = 'x; seen = 0;
    repeat (12) begin
      @(negedge clk);
      case (bus.an)
        3'b110: begin cu = bus.seg; seen |= 1; end
        3'b101: begin ct = bus.seg; seen |= 2; end
        3'b011: begin ch = bus.seg; seen |= 4; end
        default: ;
      endcase
    end
  endtask

  logic [6:0] cu, ct, ch;
  int seen, dc0, k;

  initial begin
    rst = 1'b1;
    bus.result = '0; bus.error = 1'b0; bus.result_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", bus.seg, 7'b1111111);
    check("rst_an", bus.an, 3'b111);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_scan_an", bus.an, 3'b111);
    @(negedge clk);
    check("first_scan_an", bus.an, 3'b110);
    check("first_scan_seg", bus.seg, 7'b1000000);
    capture(cu, ct, ch, seen);
    check("zero_seen", seen, 7);
    check("zero_tens", ct, 7'b1111111);
    check("zero_hund", ch, 7'b1111111);

    // Full scale: busy for 9 cycles, done on the last
    strobe(255, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      check($sformatf("fs_busy_%0d", i), bus.busy, (i <= 8) ? 1 : 0);
      check($sformatf("fs_done_%0d", i), bus.done, (i == 8) ? 1 : 0);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    capture(cu, ct, ch, seen);
    check("fs_units", cu, 7'b0010010);
    check("fs_tens", ct, 7'b0010010);
    check("fs_hund", ch, 7'b0100100);

    // Leading-zero blanking
    strobe(7, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    capture(cu, ct, ch, seen);
    check("lz7_seen", seen, 7);
    check("lz7_units", cu, 7'b1111000);
    check("lz7_tens", ct, 7'b1111111);
    check("lz7_hund", ch, 7'b1111111);
    strobe(105, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    capture(cu, ct, ch, seen);
    check("lz105_units", cu, 7'b0010010);
    check("lz105_tens", ct, 7'b1000000);
    check("lz105_hund", ch, 7'b1111001);

    // Blink: on 16 cycles after commit, off 16, on again
    strobe(100, 1'b1);
    wait_done();
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      k = n - 1;
      if ((k >= 5 && k <= 16) || (k >= 37))
        check($sformatf("blink_on_%0d", k), (bus.seg != 7'b1111111) ? 1 : 0, 1);
      else if (k >= 21 && k <= 32)
        check($sformatf("blink_off_%0d", k), bus.seg, 7'b1111111);
    end
    strobe(100, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      check($sformatf("noblink_%0d", n), (bus.seg != 7'b1111111) ? 1 : 0, 1);
    end

    // Strobes while busy are dropped; first accepted again 10 edges later
    strobe(200, 1'b0);
    dc0 = done_count;
    @(negedge clk);
    strobe(50, 1'b0);
    repeat (6) @(negedge clk);
    strobe(77, 1'b0);
    strobe(50, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_drop_done", done_count - dc0, 1);
    wait_done();
    @(negedge clk);
    check("busy_accept_done", done_count - dc0, 2);
    repeat (4) @(negedge clk);
    capture(cu, ct, ch, seen);
    check("s50_units", cu, 7'b1000000);
    check("s50_tens", ct, 7'b0010010);
    check("s50_hund", ch, 7'b1111111);

    // Reset mid-conversion aborts with no done pulse
    strobe(99, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_seg", bus.seg, 7'b1111111);
    check("arst_an", bus.an, 3'b111);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    dc0 = done_count;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_no_done", done_count - dc0, 0);
    capture(cu, ct, ch, seen);
    check("arst_units", cu, 7'b1000000);
    check("arst_tens", ct, 7'b1111111);
    check("arst_hund", ch, 7'b1111111);

    // Randomized traffic, including strobes during busy
    for (int i = 0; i < 60; i++) begin
      strobe($urandom_range(0, 255), ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    repeat (80) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
